// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared integer-pipeline constants and the writeback request record
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: result inputs, scoreboard queries, regfile write ports
interface wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int LL_DEPTH = 4
);
    localparam int CNT_W = $clog2(LL_DEPTH) + 1;

    logic              alu_wb_valid;
    logic [4:0]        alu_wb_addr;
    logic [XLEN-1:0]   alu_wb_data;

    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_addr;
    logic [XLEN-1:0]   ll_data;

    logic              iss_ll_valid;
    logic [4:0]        iss_ll_rd;

    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;

    logic [CNT_W-1:0]  ll_count;
    logic              ll_err;

    logic              write_ce;
    logic [4:0]        write_addr;
    logic [XLEN-1:0]   write_data;

    logic              w_en_2;
    logic [4:0]        w_addr_2;
    logic [XLEN-1:0]   w_data_2;

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  ll_valid, ll_addr, ll_data,
        input  iss_ll_valid, iss_ll_rd,
        input  rs1_q, rs2_q, rd_q,
        output ll_ready, rs1_busy, rs2_busy, rd_busy,
        output ll_count, ll_err,
        output write_ce, write_addr, write_data,
        output w_en_2, w_addr_2, w_data_2
    );

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output ll_valid, ll_addr, ll_data,
        output iss_ll_valid, iss_ll_rd,
        output rs1_q, rs2_q, rd_q,
        input  ll_ready, rs1_busy, rs2_busy, rd_busy,
        input  ll_count, ll_err,
        input  write_ce, write_addr, write_data,
        input  w_en_2, w_addr_2, w_data_2
    );

endinterface

// File: rtl/wb_ll_fifo.sv
// rtl/wb_ll_fifo.sv - in-order queue of long-latency writeback requests
module wb_ll_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty stay distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_req_t     mem_q [DEPTH];
    wb_req_t     mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    always_comb begin
        count   = wr_ptr_q - rd_ptr_q;
        full    = (count == (AW+1)'(DEPTH));
        empty   = (wr_ptr_q == rd_ptr_q);
        head    = mem_q[rd_ptr_q[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback stage: ALU results on port 1, queued long-latency results on port 2,
// plus the pending-destination scoreboard consulted by issue.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int LL_DEPTH = 4,
    parameter int XLEN     = cpu_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(LL_DEPTH) + 1;

    logic             write_ce_q,   write_ce_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;
    logic             w_en_2_q,     w_en_2_d;
    logic [4:0]       w_addr_2_q,   w_addr_2_d;
    logic [XLEN-1:0]  w_data_2_q,   w_data_2_d;
    logic [NREGS-1:0] pending_q,    pending_d;
    logic             ll_err_q,     ll_err_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    wb_req_t          push_req;
    wb_req_t          head;
    logic [CNT_W-1:0] fifo_count;

    logic             port1_wr;
    logic             collision;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    wb_ll_fifo #(
        .DEPTH (LL_DEPTH)
    ) u_ll_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A port-1 write to the head's rd this cycle holds the head, so the
    // younger long-latency value never lands in the same cycle as the ALU one.
    always_comb begin
        port1_wr  = bus.alu_wb_valid && (bus.alu_wb_addr != '0);
        collision = port1_wr && !fifo_empty && (head.rd == bus.alu_wb_addr);
        fifo_pop  = !fifo_empty && !collision;
        fifo_push = bus.ll_valid && !fifo_full;
        push_req  = '{rd: bus.ll_addr, data: bus.ll_data};
    end

    always_comb begin
        write_ce_d   = port1_wr;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (bus.alu_wb_valid) begin
            write_addr_d = bus.alu_wb_addr;
            write_data_d = bus.alu_wb_data;
        end

        w_en_2_d   = 1'b0;
        w_addr_2_d = w_addr_2_q;
        w_data_2_d = w_data_2_q;
        if (fifo_pop) begin
            w_en_2_d   = (head.rd != '0);
            w_addr_2_d = head.rd;
            w_data_2_d = head.data;
        end
    end

    // Set is applied after clear so a re-issue of the rd being retired stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.iss_ll_valid && (bus.iss_ll_rd != '0)) begin
            set_mask[bus.iss_ll_rd] = 1'b1;
        end
        if (fifo_pop && (head.rd != '0)) begin
            clr_mask[head.rd] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;

        ll_err_d = ll_err_q;
        if (fifo_push && (bus.ll_addr != '0) && !pending_q[bus.ll_addr]) begin
            ll_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_ce_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            w_en_2_q     <= 1'b0;
            w_addr_2_q   <= '0;
            w_data_2_q   <= '0;
            pending_q    <= '0;
            ll_err_q     <= 1'b0;
        end else begin
            write_ce_q   <= write_ce_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            w_en_2_q     <= w_en_2_d;
            w_addr_2_q   <= w_addr_2_d;
            w_data_2_q   <= w_data_2_d;
            pending_q    <= pending_d;
            ll_err_q     <= ll_err_d;
        end
    end

    assign bus.ll_ready   = !fifo_full;
    assign bus.ll_count   = fifo_count;
    assign bus.ll_err     = ll_err_q;
    assign bus.rs1_busy   = (bus.rs1_q != '0) && pending_q[bus.rs1_q];
    assign bus.rs2_busy   = (bus.rs2_q != '0) && pending_q[bus.rs2_q];
    assign bus.rd_busy    = (bus.rd_q  != '0) && pending_q[bus.rd_q];
    assign bus.write_ce   = write_ce_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.w_en_2     = w_en_2_q;
    assign bus.w_addr_2   = w_addr_2_q;
    assign bus.w_data_2   = w_data_2_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter: expected regfile writes queued at stimulus time
module tb_wb_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32), .LL_DEPTH(4)) bus ();

    wb_arbiter #(.LL_DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp1[$];
    wr_t exp2[$];
    wr_t e1;
    wr_t e2;
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Monitor: compare every regfile write against the head of its expectation queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                if (bus.write_ce === 1'b1) begin
                    if (exp1.size() == 0) check("p1_unexpected_write", 64'(bus.write_addr), 64'hFF);
                    else begin
                        e1 = exp1.pop_front();
                        check("p1_addr", 64'(bus.write_addr), 64'(e1.a));
                        check("p1_data", 64'(bus.write_data), 64'(e1.d));
                    end
                end
                if (bus.w_en_2 === 1'b1) begin
                    if (exp2.size() == 0) check("p2_unexpected_write", 64'(bus.w_addr_2), 64'hFF);
                    else begin
                        e2 = exp2.pop_front();
                        check("p2_addr", 64'(bus.w_addr_2), 64'(e2.a));
                        check("p2_data", 64'(bus.w_data_2), 64'(e2.d));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_wb_valid = 1'b0;
        bus.ll_valid     = 1'b0;
        bus.iss_ll_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = a;
        bus.alu_wb_data  = d;
        if (a != 5'd0) exp1.push_back('{a, d});
    endtask

    task automatic ll_push(input logic [4:0] a, input logic [31:0] d, input bit accept);
        bus.ll_valid = 1'b1;
        bus.ll_addr  = a;
        bus.ll_data  = d;
        if (accept && a != 5'd0) exp2.push_back('{a, d});
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_ll_valid = 1'b1;
        bus.iss_ll_rd    = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
        bus.ll_addr = '0; bus.ll_data = '0; bus.iss_ll_rd = '0;
        bus.rs1_q = '0; bus.rs2_q = '0; bus.rd_q = '0;
        repeat (2) nxt();
        check("rst_write_ce", 64'(bus.write_ce), 0);
        check("rst_write_addr", 64'(bus.write_addr), 0);
        check("rst_write_data", 64'(bus.write_data), 0);
        check("rst_w_en_2", 64'(bus.w_en_2), 0);
        check("rst_w_addr_2", 64'(bus.w_addr_2), 0);
        check("rst_ll_count", 64'(bus.ll_count), 0);
        check("rst_ll_ready", 64'(bus.ll_ready), 1);
        check("rst_ll_err", 64'(bus.ll_err), 0);
        rst_n = 1'b1;

        // Port 1 latency and the x0 suppression
        alu(5'd5, 32'hDEADBEEF); nxt();
        check("p1_ce_after_edge", 64'(bus.write_ce), 1);
        check("p1_addr_after_edge", 64'(bus.write_addr), 5);
        alu(5'd0, 32'h1111); nxt(); idle();
        check("p1_x0_ce", 64'(bus.write_ce), 0);
        check("p1_x0_addr_loaded", 64'(bus.write_addr), 0);

        // Scoreboard set, push, pop-and-clear
        issue(5'd7); nxt(); idle();
        bus.rs1_q = 5'd7; #1;
        check("rs1_busy_set", 64'(bus.rs1_busy), 1);
        ll_push(5'd7, 32'h1234, 1); nxt(); idle();
        check("count_after_push", 64'(bus.ll_count), 1);
        check("no_w2_on_push_edge", 64'(bus.w_en_2), 0);
        nxt();
        check("w2_en_pop", 64'(bus.w_en_2), 1);
        check("w2_addr_pop", 64'(bus.w_addr_2), 7);
        check("w2_data_pop", 64'(bus.w_data_2), 32'h1234);
        #1;
        check("rs1_busy_cleared", 64'(bus.rs1_busy), 0);

        // Fill the FIFO while collisions hold the head at rd 10
        for (int i = 0; i < 4; i++) begin
            issue(5'(10 + i)); nxt();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            alu(5'd10, 32'hA0 + 32'(i));
            ll_push(5'(10 + i), 32'h100 + 32'(i), 1);
            nxt();
        end
        bus.rd_q = 5'd13; #1;
        check("full_count", 64'(bus.ll_count), 4);
        check("full_ready", 64'(bus.ll_ready), 0);
        check("rd_busy_13", 64'(bus.rd_busy), 1);
        alu(5'd10, 32'hAF);
        ll_push(5'd14, 32'h999, 0);
        nxt(); idle();
        check("fifth_rejected_count", 64'(bus.ll_count), 4);
        repeat (5) nxt();
        check("drained_count", 64'(bus.ll_count), 0);
        #1;
        check("rd_busy_13_cleared", 64'(bus.rd_busy), 0);

        // Collision delays the head by exactly one cycle
        issue(5'd9); nxt(); idle();
        ll_push(5'd9, 32'h99, 1); nxt(); idle();
        alu(5'd9, 32'h55); nxt(); idle();
        check("collision_w_en_2", 64'(bus.w_en_2), 0);
        check("collision_count", 64'(bus.ll_count), 1);
        nxt();
        check("post_collision_en", 64'(bus.w_en_2), 1);
        check("post_collision_addr", 64'(bus.w_addr_2), 9);

        // Non-pending push flags ll_err; same-cycle issue and retire keeps pending
        check("ll_err_before", 64'(bus.ll_err), 0);
        ll_push(5'd3, 32'h33, 1); nxt(); idle();
        check("ll_err_set", 64'(bus.ll_err), 1);
        nxt();
        check("rd3_written", 64'(bus.w_addr_2), 3);
        repeat (2) nxt();
        check("ll_err_sticky", 64'(bus.ll_err), 1);
        issue(5'd4); nxt(); idle();
        ll_push(5'd4, 32'h44, 1); nxt(); idle();
        issue(5'd4); nxt(); idle();
        check("rd4_pop_en", 64'(bus.w_en_2), 1);
        check("rd4_pop_addr", 64'(bus.w_addr_2), 4);
        bus.rs2_q = 5'd4; #1;
        check("rd4_set_wins", 64'(bus.rs2_busy), 1);

        // Asynchronous reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            issue(5'(20 + i)); nxt();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            alu(5'd20, 32'hC0 + 32'(i));
            ll_push(5'(20 + i), 32'h200 + 32'(i), 1);
            nxt();
        end
        idle();
        bus.rs1_q = 5'd21; #1;
        check("pre_rst_count", 64'(bus.ll_count), 3);
        check("pre_rst_busy", 64'(bus.rs1_busy), 1);
        check("pre_rst_write_ce", 64'(bus.write_ce), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_write_ce", 64'(bus.write_ce), 0);
        check("async_write_addr", 64'(bus.write_addr), 0);
        check("async_w_en_2", 64'(bus.w_en_2), 0);
        check("async_count", 64'(bus.ll_count), 0);
        check("async_ready", 64'(bus.ll_ready), 1);
        check("async_ll_err", 64'(bus.ll_err), 0);
        check("async_busy", 64'(bus.rs1_busy), 0);
        exp2.delete();
        repeat (2) nxt();
        rst_n = 1'b1;
        repeat (6) nxt();
        check("post_rst_count", 64'(bus.ll_count), 0);
        check("post_rst_w_en_2", 64'(bus.w_en_2), 0);

        nxt();
        check("exp1_drained", 64'(exp1.size()), 0);
        check("exp2_drained", 64'(exp2.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
